// File: rtl/mdu_ctrl.sv
// HI/LO owner and sequencer for the serial 32x32 multiplier: launches multiplies,
// stalls execute while a product is pending, and handles flush and watchdog abort.
module mdu_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_req,
    input  logic [1:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_req,
    input  logic        mf_sel,
    input  logic        flush,
    output logic [31:0] mf_data,
    output logic        stall,
    output logic        busy,
    output logic        err,
    output logic        mst,
    output logic        msgn,
    output logic [31:0] a,
    output logic [31:0] b,
    input  logic [63:0] prod,
    input  logic        prodv
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic          mst_q;
    logic          msgn_q;
    logic          busy_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;
    logic          accept;

    // A flush in the same cycle as an IDLE request squashes that request.
    assign accept = (state_q == S_IDLE) && md_req && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mst_q   <= 1'b0;
            msgn_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            mst_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (!md_op[1]) begin
                            a_q     <= rs_val;
                            b_q     <= rt_val;
                            msgn_q  <= ~md_op[0];
                            mst_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= S_START;
                        end else if (md_op[0]) begin
                            lo_q <= rs_val;
                        end else begin
                            hi_q <= rs_val;
                        end
                    end
                end
                S_START: begin
                    cnt_q <= '0;
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (prodv) begin
                        hi_q    <= prod[63:32];
                        lo_q    <= prod[31:0];
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // A flush during START suppresses the already-registered start pulse.
    assign mst     = mst_q & ~flush;
    assign msgn    = msgn_q;
    assign a       = a_q;
    assign b       = b_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign stall   = (state_q != S_IDLE) && (md_req || mf_req);
    assign mf_data = mf_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a fixed-latency behavioural multiplier.
module tb_mdu_ctrl;

    localparam int LAT = 8;

    logic        clk;
    logic        rst;
    logic        md_req;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mf_req;
    logic        mf_sel;
    logic        flush;
    logic [31:0] mf_data;
    logic        stall;
    logic        busy;
    logic        err;
    logic        mst;
    logic        msgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic        prodv;

    int errors = 0;
    int checks = 0;

    logic        model_en;
    logic        force_v;
    logic [63:0] force_prod;
    logic [63:0] model_prod;
    logic        model_pend;
    int          model_cd;

    mdu_ctrl #(.TIMEOUT(64), .CW(7)) dut (
        .clk(clk), .rst(rst), .md_req(md_req), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .mf_req(mf_req), .mf_sel(mf_sel),
        .flush(flush), .mf_data(mf_data), .stall(stall), .busy(busy),
        .err(err), .mst(mst), .msgn(msgn), .a(a), .b(b),
        .prod(prod), .prodv(prodv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_pend <= 1'b0;
            model_cd   <= 0;
            model_prod <= '0;
        end else if (mst && model_en) begin
            model_pend <= 1'b1;
            model_cd   <= LAT;
            model_prod <= msgn ? ({{32{a[31]}}, a} * {{32{b[31]}}, b})
                               : ({32'h0, a} * {32'h0, b});
        end else if (model_pend) begin
            model_cd <= model_cd - 1;
            if (model_cd == 1) model_pend <= 1'b0;
        end
    end

    assign prodv = force_v | (model_pend && model_cd == 1);
    assign prod  = force_v ? force_prod : model_prod;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    // Issue one multiply and follow it to completion with an MFHI held stalled.
    task automatic run_mult(input logic [1:0] op, input logic [31:0] ra, input logic [31:0] rb,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input logic exp_sgn, input string tag);
        int n;
        int extra;
        int stall_bad;
        md_req = 1'b1; md_op = op; rs_val = ra; rt_val = rb; mf_req = 1'b0;
        #1;
        cmp({tag, " accept_stall"}, {31'b0, stall}, 32'd0);
        tick();
        cmp({tag, " mst_pulse"}, {31'b0, mst}, 32'd1);
        cmp({tag, " msgn"}, {31'b0, msgn}, {31'b0, exp_sgn});
        cmp({tag, " a"}, a, ra);
        cmp({tag, " b"}, b, rb);
        cmp({tag, " busy"}, {31'b0, busy}, 32'd1);
        md_req = 1'b0; mf_req = 1'b1; mf_sel = 1'b1;
        #1;
        cmp({tag, " mf_stall"}, {31'b0, stall}, 32'd1);
        n = 0; extra = 0; stall_bad = 0;
        while (n < 200) begin
            tick();
            n++;
            if (busy !== 1'b1) break;
            if (mst === 1'b1) extra++;
            if (stall !== 1'b1) stall_bad++;
        end
        cmp({tag, " done"}, {31'b0, busy}, 32'd0);
        cmp({tag, " extra_mst"}, extra, 32'd0);
        cmp({tag, " stall_while_busy"}, stall_bad, 32'd0);
        cmp({tag, " stall_after"}, {31'b0, stall}, 32'd0);
        cmp({tag, " HI"}, mf_data, exp_hi);
        mf_sel = 1'b0;
        #1;
        cmp({tag, " LO"}, mf_data, exp_lo);
        mf_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; md_req = 1'b0; md_op = 2'b00; rs_val = '0; rt_val = '0;
        mf_req = 1'b0; mf_sel = 1'b0; flush = 1'b0;
        model_en = 1'b1; force_v = 1'b0; force_prod = '0;
        tick(); tick();
        cmp("rst busy", {31'b0, busy}, 32'd0);
        cmp("rst err", {31'b0, err}, 32'd0);
        cmp("rst mst", {31'b0, mst}, 32'd0);
        cmp("rst msgn", {31'b0, msgn}, 32'd0);
        cmp("rst a", a, 32'd0);
        cmp("rst b", b, 32'd0);
        cmp("rst LO", mf_data, 32'd0);
        mf_sel = 1'b1;
        #1;
        cmp("rst HI", mf_data, 32'd0);
        mf_sel = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_mult_signed();
        run_mult(2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b1, "mult_max");
    endtask

    task automatic test_mult_minus_one();
        run_mult(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_ff");
        run_mult(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b1, "mult_ff");
    endtask

    task automatic test_mthi_mtlo();
        int mst_seen;
        mst_seen = 0;
        md_req = 1'b1; md_op = 2'b10; rs_val = 32'hDEADBEEF;
        mf_req = 1'b1; mf_sel = 1'b1;
        #1;
        cmp("mthi stall", {31'b0, stall}, 32'd0);
        cmp("mthi pre_update_HI", mf_data, 32'h00000000);
        tick();
        if (mst === 1'b1) mst_seen++;
        mf_req = 1'b0;
        md_op = 2'b11; rs_val = 32'h12345678;
        #1;
        cmp("mtlo stall", {31'b0, stall}, 32'd0);
        tick();
        if (mst === 1'b1) mst_seen++;
        md_req = 1'b0; mf_req = 1'b1; mf_sel = 1'b1;
        #1;
        cmp("mfhi", mf_data, 32'hDEADBEEF);
        mf_sel = 1'b0;
        #1;
        cmp("mflo", mf_data, 32'h12345678);
        tick();
        if (mst === 1'b1) mst_seen++;
        cmp("mt no_mst", mst_seen, 32'd0);
        cmp("mt busy", {31'b0, busy}, 32'd0);
        mf_req = 1'b0;
    endtask

    task automatic test_flush();
        md_req = 1'b1; md_op = 2'b00; rs_val = 32'd3; rt_val = 32'd5;
        tick();
        md_req = 1'b0;
        tick(); tick();
        flush = 1'b1; mf_req = 1'b1; mf_sel = 1'b1;
        #1;
        cmp("flush busy_before", {31'b0, busy}, 32'd1);
        tick();
        flush = 1'b0;
        #1;
        cmp("flush busy", {31'b0, busy}, 32'd0);
        cmp("flush stall", {31'b0, stall}, 32'd0);
        force_v = 1'b1; force_prod = 64'h1_00000002;
        tick();
        force_v = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        cmp("flush HI", mf_data, 32'hDEADBEEF);
        mf_sel = 1'b0;
        #1;
        cmp("flush LO", mf_data, 32'h12345678);
        mf_req = 1'b0;

        // flush and prodv in the same BUSY cycle
        model_en = 1'b0;
        md_req = 1'b1; md_op = 2'b01; rs_val = 32'd7; rt_val = 32'd9;
        tick();
        md_req = 1'b0;
        tick();
        flush = 1'b1; force_v = 1'b1; force_prod = 64'hAAAAAAAA_55555555;
        tick();
        flush = 1'b0; force_v = 1'b0;
        #1;
        cmp("flush_prio busy", {31'b0, busy}, 32'd0);
        cmp("flush_prio LO", mf_data, 32'h12345678);

        // flush in IDLE blocks both a multiply and an MTLO
        md_req = 1'b1; md_op = 2'b00; flush = 1'b1;
        tick();
        cmp("flush_idle busy", {31'b0, busy}, 32'd0);
        cmp("flush_idle mst", {31'b0, mst}, 32'd0);
        md_op = 2'b11; rs_val = 32'h0BADF00D;
        tick();
        md_req = 1'b0; flush = 1'b0;
        #1;
        cmp("flush_idle LO", mf_data, 32'h12345678);
        tick();
    endtask

    task automatic test_timeout();
        int nb;
        int err_early;
        model_en = 1'b0;
        md_req = 1'b1; md_op = 2'b00; rs_val = 32'd11; rt_val = 32'd13;
        tick();
        md_req = 1'b0;
        nb = 0; err_early = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            if (err === 1'b1) err_early++;
            tick();
        end
        cmp("timeout busy_cycles", nb, 32'd65);
        cmp("timeout err_early", err_early, 32'd0);
        cmp("timeout err", {31'b0, err}, 32'd1);
        mf_req = 1'b1; mf_sel = 1'b1;
        #1;
        cmp("timeout stall", {31'b0, stall}, 32'd0);
        cmp("timeout HI", mf_data, 32'hDEADBEEF);
        mf_sel = 1'b0;
        #1;
        cmp("timeout LO", mf_data, 32'h12345678);
        mf_req = 1'b0;
        md_req = 1'b1; md_op = 2'b10; rs_val = 32'h00000042;
        tick();
        md_req = 1'b0;
        tick(); tick();
        cmp("timeout err_sticky", {31'b0, err}, 32'd1);
    endtask

    task automatic test_reset_mid_op();
        model_en = 1'b1;
        md_req = 1'b1; md_op = 2'b00; rs_val = 32'd3; rt_val = 32'd3;
        tick();
        md_req = 1'b0;
        cmp("arst mst_before", {31'b0, mst}, 32'd1);
        rst = 1'b0;
        #1;
        cmp("arst mst", {31'b0, mst}, 32'd0);
        cmp("arst busy", {31'b0, busy}, 32'd0);
        cmp("arst err", {31'b0, err}, 32'd0);
        cmp("arst a", a, 32'd0);
        mf_req = 1'b1; mf_sel = 1'b1;
        #1;
        cmp("arst HI", mf_data, 32'd0);
        cmp("arst stall", {31'b0, stall}, 32'd0);
        mf_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        run_mult(2'b00, 32'h00000001, 32'h40000000, 32'h00000000, 32'h40000000, 1'b1, "post_rst");
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_mult_minus_one();
        test_mthi_mtlo();
        test_flush();
        test_timeout();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
